seq_data_memory: RTL and testbench

//  Memory stage of the sequential Y86-64 processor: decodes icode into a data-memory read or write.

---
 rtl/y86_pkg.sv | 17 +
 rtl/seq_data_memory_if.sv | 30 +++
 rtl/dmem_ram.sv | 39 +++
 rtl/seq_data_memory.sv | 89 ++++++++
 tb/tb_seq_data_memory.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: constants shared by the Y86-64 sequential memory stage.
//   WORD_W     data and address width of the machine word
//   DMEM_DEPTH default number of 64-bit words in data memory
//   I*         instruction codes that touch data memory
package y86_pkg;

  localparam int WORD_W     = 64;
  localparam int DMEM_DEPTH = 1024;

  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

endpackage : y86_pkg

// File: rtl/seq_data_memory_if.sv
// seq_data_memory_if: bundle between the datapath and the memory stage.
//   icode        instruction code of the current instruction
//   valA         decoded register A (store data / pop-ret address)
//   valP         incremented PC (return address pushed by call)
//   valE         ALU result (store/load/push/call address)
//   valM         data read from memory
//   DataMemError selected access address is out of range
// Modports: master drives the request, slave (the memory stage) answers.
interface seq_data_memory_if
  import y86_pkg::*;
  ();

  logic        [3:0]        icode;
  logic signed [WORD_W-1:0] valA;
  logic signed [WORD_W-1:0] valP;
  logic signed [WORD_W-1:0] valE;
  logic        [WORD_W-1:0] valM;
  logic                     DataMemError;

  modport master (
    output icode, valA, valP, valE,
    input  valM, DataMemError
  );

  modport slave (
    input  icode, valA, valP, valE,
    output valM, DataMemError
  );

endinterface : seq_data_memory_if

// File: rtl/dmem_ram.sv
// dmem_ram: plain storage for the data memory, no decode.
//   clk    clock; writes and clear happen on the rising edge
//   rst_n  synchronous active-low clear of every word; blocks the write
//   we     write enable (caller has already range-checked the address)
//   waddr  write word index, wdata write data
//   raddr  asynchronous read word index, rdata read data
module dmem_ram
  import y86_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // NOTE: clearing an array in reset turns it into a bank of flops rather
  // than a RAM macro; it is kept because reset must zero every word.
  // NOTE: non-blocking assignments so every read this cycle sees old data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : dmem_ram

// File: rtl/seq_data_memory.sv
// seq_data_memory: memory stage of the sequential Y86-64 processor.
//   Clk    clock, all state updates on rising edge
//   Rst_n  synchronous active-low reset (clears memory, forces outputs to 0)
//   bus    seq_data_memory_if.slave: icode/valA/valP/valE in, valM/DataMemError out
// Decodes icode into a read or write, selects address and store data,
// range-checks the signed address and gates the outputs.
// Build option: define DMEM_READ_REG_EN to register valM and DataMemError
// (one-cycle read latency); default is a combinational read path.
module seq_data_memory
  import y86_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic               Clk,
  input  logic               Rst_n,
  seq_data_memory_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  logic              rd_en;
  logic              wr_en;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              addr_ok;
  logic [WORD_W-1:0] rdata;
  logic [WORD_W-1:0] valm_d;
  logic              err_d;

  // NOTE: every output of a combinational block gets a default first so no
  // icode path leaves a variable unassigned (which would infer a latch).
  always_comb begin
    rd_en = 1'b0;
    wr_en = 1'b0;
    addr  = '0;
    wdata = '0;
    case (bus.icode)
      IRMMOVQ: begin wr_en = 1'b1; addr = bus.valE; wdata = bus.valA; end
      IMRMOVQ: begin rd_en = 1'b1; addr = bus.valE;                   end
      ICALL:   begin wr_en = 1'b1; addr = bus.valE; wdata = bus.valP; end
      IRET:    begin rd_en = 1'b1; addr = bus.valA;                   end
      IPUSHQ:  begin wr_en = 1'b1; addr = bus.valE; wdata = bus.valA; end
      IPOPQ:   begin rd_en = 1'b1; addr = bus.valA;                   end
      default: ;
    endcase
  end

  // Sign bit set means a negative address; otherwise the full 64-bit value
  // must be below DEPTH, so high bits can never alias into the array.
  assign addr_ok = !addr[WORD_W-1] && (addr < WORD_W'(DEPTH));

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (Clk),
    .rst_n (Rst_n),
    .we    (wr_en && addr_ok),
    .waddr (addr[AW-1:0]),
    .wdata (wdata),
    .raddr (addr[AW-1:0]),
    .rdata (rdata)
  );

  assign valm_d = (Rst_n && rd_en && addr_ok) ? rdata : '0;
  assign err_d  = Rst_n && (rd_en || wr_en) && !addr_ok;

`ifdef DMEM_READ_REG_EN
  logic [WORD_W-1:0] valm_q;
  logic              err_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      valm_q <= '0;
      err_q  <= 1'b0;
    end else begin
      valm_q <= valm_d;
      err_q  <= err_d;
    end
  end

  assign bus.valM         = valm_q;
  assign bus.DataMemError = err_q;
`else
  assign bus.valM         = valm_d;
  assign bus.DataMemError = err_d;
`endif

endmodule : seq_data_memory

// File: tb/tb_seq_data_memory.sv
// tb_seq_data_memory: scoreboard bench for seq_data_memory.
// Each op is pushed to the scoreboard as it is driven and popped when the
// DUT output for it is sampled. Handles either read-path build.
module tb_seq_data_memory;

  logic Clk = 1'b0;
  logic Rst_n;

  always #5 Clk = ~Clk;

  seq_data_memory_if bus ();

  seq_data_memory #(.DEPTH(1024)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  ic;
    logic [63:0] a;
    logic [63:0] p;
    logic [63:0] e;
    logic        vm_chk;  // valM is only defined for reads, idle, errors, reset
    logic [63:0] valm;
    logic        err;
  } op_t;

  op_t sb [$];
  int  n_run  = 0;
  int  n_fail = 0;

  function automatic op_t mk(input logic r, input logic [3:0] ic,
                             input logic [63:0] a, input logic [63:0] p,
                             input logic [63:0] e, input logic vc,
                             input logic [63:0] vm, input logic er);
    op_t o;
    o.rst_n = r; o.ic = ic; o.a = a; o.p = p; o.e = e;
    o.vm_chk = vc; o.valm = vm; o.err = er;
    return o;
  endfunction

  // Drive one op just after a rising edge, sample its result, and return
  // positioned just after the edge that committed it.
  task automatic apply(input op_t o, output logic [63:0] ov, output logic oe);
    Rst_n     = o.rst_n;
    bus.icode = o.ic;
    bus.valA  = o.a;
    bus.valP  = o.p;
    bus.valE  = o.e;
`ifdef DMEM_READ_REG_EN
    @(posedge Clk); #1;
    ov = bus.valM;
    oe = bus.DataMemError;
`else
    @(negedge Clk);
    ov = bus.valM;
    oe = bus.DataMemError;
    @(posedge Clk); #1;
`endif
  endtask

  task automatic test_reset();
    op_t ops [$];
    op_t ex;
    logic [63:0] ov;
    logic oe;
    ops.push_back(mk(0, 4'h5, 0, 0, 0, 1, 0, 0));
    ops.push_back(mk(0, 4'h4, 5, 0, 2000, 1, 0, 0));
    ops.push_back(mk(0, 4'h9, 64'(-1), 0, 0, 1, 0, 0));
    ops.push_back(mk(1, 4'h5, 0, 0, 0, 1, 0, 0));
    ops.push_back(mk(1, 4'hB, 1023, 0, 0, 1, 0, 0));
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      apply(ops[i], ov, oe);
      ex = sb.pop_front();
      n_run++;
      if ((ex.vm_chk && ov !== ex.valm) || oe !== ex.err) begin
        n_fail++;
        $display("FAIL reset[%0d]: got valM=%0d err=%b, want valM=%0d err=%b",
                 i, ov, oe, ex.valm, ex.err);
      end
    end
  endtask

  task automatic test_store_load();
    op_t ops [$];
    op_t ex;
    logic [63:0] ov;
    logic oe;
    ops.push_back(mk(1, 4'h4, 732, 0, 261, 0, 0, 0));
    ops.push_back(mk(1, 4'h5, 0, 0, 261, 1, 732, 0));
    ops.push_back(mk(1, 4'h8, 999, 4, 124, 0, 0, 0));
    ops.push_back(mk(1, 4'h9, 124, 0, 7, 1, 4, 0));
    ops.push_back(mk(1, 4'hB, 261, 0, 0, 1, 732, 0));
    ops.push_back(mk(1, 4'h5, 0, 0, 262, 1, 0, 0));
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      apply(ops[i], ov, oe);
      ex = sb.pop_front();
      n_run++;
      if ((ex.vm_chk && ov !== ex.valm) || oe !== ex.err) begin
        n_fail++;
        $display("FAIL store_load[%0d]: got valM=%0d err=%b, want valM=%0d err=%b",
                 i, ov, oe, ex.valm, ex.err);
      end
    end
  endtask

  task automatic test_bounds();
    op_t ops [$];
    op_t ex;
    logic [63:0] ov;
    logic oe;
    ops.push_back(mk(1, 4'hA, 124, 0, 1284, 1, 0, 1));          // push out of range
    ops.push_back(mk(1, 4'hB, 1284, 0, 0, 1, 0, 1));            // pop out of range
    ops.push_back(mk(1, 4'h2, 124, 0, 1284, 1, 0, 0));          // no access
    ops.push_back(mk(1, 4'h9, 124, 0, 0, 1, 4, 0));             // word 124 intact
    ops.push_back(mk(1, 4'h4, 55, 0, 1023, 0, 0, 0));           // last word
    ops.push_back(mk(1, 4'h5, 0, 0, 1023, 1, 55, 0));
    ops.push_back(mk(1, 4'h4, 64'hDEAD, 0, 1024, 1, 0, 1));     // must not wrap to 0
    ops.push_back(mk(1, 4'h5, 0, 0, 0, 1, 0, 0));
    ops.push_back(mk(1, 4'h4, 7, 0, 64'(-1), 1, 0, 1));         // must not wrap to 1023
    ops.push_back(mk(1, 4'h5, 0, 0, 1023, 1, 55, 0));
    ops.push_back(mk(1, 4'h5, 0, 0, 64'(-1), 1, 0, 1));
    ops.push_back(mk(1, 4'hB, 1024, 0, 0, 1, 0, 1));
    ops.push_back(mk(1, 4'h5, 0, 0, 64'h8000_0000_0000_0000, 1, 0, 1));
    ops.push_back(mk(1, 4'h5, 0, 0, 64'h0000_0001_0000_03FF, 1, 0, 1));
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      apply(ops[i], ov, oe);
      ex = sb.pop_front();
      n_run++;
      if ((ex.vm_chk && ov !== ex.valm) || oe !== ex.err) begin
        n_fail++;
        $display("FAIL bounds[%0d]: got valM=%0d err=%b, want valM=%0d err=%b",
                 i, ov, oe, ex.valm, ex.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    op_t ops [$];
    op_t ex;
    logic [63:0] ov;
    logic oe;
    ops.push_back(mk(1, 4'h4, 99, 0, 10, 0, 0, 0));
    ops.push_back(mk(1, 4'h5, 0, 0, 10, 1, 99, 0));
    ops.push_back(mk(0, 4'h4, 77, 0, 10, 1, 0, 0));             // write aborted by reset
    ops.push_back(mk(1, 4'h5, 0, 0, 10, 1, 0, 0));
    ops.push_back(mk(1, 4'h5, 0, 0, 1023, 1, 0, 0));            // cleared too
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      apply(ops[i], ov, oe);
      ex = sb.pop_front();
      n_run++;
      if ((ex.vm_chk && ov !== ex.valm) || oe !== ex.err) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got valM=%0d err=%b, want valM=%0d err=%b",
                 i, ov, oe, ex.valm, ex.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t ops [$];
    op_t ex;
    logic [63:0] ov;
    logic oe;
    logic [63:0] addr [8];
    logic [63:0] data [8];
    logic [3:0]  wr_ic [3] = '{4'h4, 4'h8, 4'hA};
    logic [3:0]  rd_ic [3] = '{4'h5, 4'h9, 4'hB};
    logic [3:0]  ic;
    for (int i = 0; i < 8; i++) begin
      addr[i] = 64'(i * 100 + $urandom_range(0, 99));
      data[i] = {$urandom, $urandom};
      ic = wr_ic[$urandom_range(0, 2)];
      if (ic == 4'h8) ops.push_back(mk(1, ic, {$urandom, $urandom}, data[i], addr[i], 0, 0, 0));
      else            ops.push_back(mk(1, ic, data[i], {$urandom, $urandom}, addr[i], 0, 0, 0));
    end
    for (int i = 7; i >= 0; i--) begin
      ic = rd_ic[$urandom_range(0, 2)];
      if (ic == 4'h5) ops.push_back(mk(1, ic, {$urandom, $urandom}, 0, addr[i], 1, data[i], 0));
      else            ops.push_back(mk(1, ic, addr[i], 0, {$urandom, $urandom}, 1, data[i], 0));
    end
    foreach (ops[i]) begin
      sb.push_back(ops[i]);
      apply(ops[i], ov, oe);
      ex = sb.pop_front();
      n_run++;
      if ((ex.vm_chk && ov !== ex.valm) || oe !== ex.err) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got valM=%0h err=%b, want valM=%0h err=%b",
                 i, ov, oe, ex.valm, ex.err);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    Rst_n     = 1'b0;
    bus.icode = 4'h0;
    bus.valA  = '0;
    bus.valP  = '0;
    bus.valE  = '0;
    @(posedge Clk); #1;
    test_reset();
    test_store_load();
    test_bounds();
    test_reset_mid();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule : tb_seq_data_memory
